// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one synchronous single-ported RAM between the
// instruction-fetch port and the data load/store port. Grants are issued
// in the same cycle as the request, with round-robin fairness when both
// ports request together. Read data returns one cycle after the grant.
// The block also drives a stall flag and a saturating contention counter.
module mem_port_arbiter #(
  parameter int ADDR_WIDTH     = 10,
  parameter int DATA_WIDTH     = 32,
  parameter int TRANSFER_WIDTH = 4,
  parameter int CNT_WIDTH      = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      if_req_i,
  input  logic [ADDR_WIDTH-1:0]     if_addr_i,
  output logic                      if_gnt_o,
  output logic                      if_rvalid_o,
  output logic [DATA_WIDTH-1:0]     if_rdata_o,
  input  logic                      d_req_i,
  input  logic                      d_we_i,
  input  logic [ADDR_WIDTH-1:0]     d_addr_i,
  input  logic [DATA_WIDTH-1:0]     d_wdata_i,
  input  logic [TRANSFER_WIDTH-1:0] d_be_i,
  output logic                      d_gnt_o,
  output logic                      d_rvalid_o,
  output logic [DATA_WIDTH-1:0]     d_rdata_o,
  output logic                      mem_en_o,
  output logic                      mem_we_o,
  output logic [ADDR_WIDTH-1:0]     mem_addr_o,
  output logic [DATA_WIDTH-1:0]     mem_wdata_o,
  output logic [TRANSFER_WIDTH-1:0] mem_be_o,
  input  logic [DATA_WIDTH-1:0]     mem_rdata_i,
  output logic                      stall_o,
  output logic [CNT_WIDTH-1:0]      conflict_cnt_o
);

  typedef enum logic [1:0] {
    OWN_NONE  = 2'd0,
    OWN_FETCH = 2'd1,
    OWN_DATA  = 2'd2
  } owner_e;

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  owner_e                  winner;
  owner_e                  last_winner_q, last_winner_d;
  owner_e                  rsp_owner_q, rsp_owner_d;
  logic                    rsp_we_q, rsp_we_d;
  logic [DATA_WIDTH-1:0]   if_rdata_q, if_rdata_d;
  logic [DATA_WIDTH-1:0]   d_rdata_q, d_rdata_d;
  logic [CNT_WIDTH-1:0]    cnt_q, cnt_d;
  logic                    contention;

  // Both ports requesting outside reset is the only case that moves the
  // round-robin pointer or the performance counter.
  assign contention = if_req_i && d_req_i && !rst;

  // Pick this cycle's winner: a lone requester always wins, on contention
  // the port that did not win the previous contention goes first.
  always_comb begin
    winner = OWN_NONE;
    if (!rst) begin
      if (if_req_i && d_req_i) begin
        winner = (last_winner_q == OWN_FETCH) ? OWN_DATA : OWN_FETCH;
      end else if (if_req_i) begin
        winner = OWN_FETCH;
      end else if (d_req_i) begin
        winner = OWN_DATA;
      end
    end
  end

  assign if_gnt_o = (winner == OWN_FETCH);
  assign d_gnt_o  = (winner == OWN_DATA);
  assign stall_o  = !rst && ((if_req_i && !if_gnt_o) || (d_req_i && !d_gnt_o));

  // Steer the winner's access onto the RAM port; idle cycles drive zeros.
  always_comb begin
    mem_en_o    = 1'b0;
    mem_we_o    = 1'b0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    mem_be_o    = '0;
    if (winner == OWN_FETCH) begin
      mem_en_o   = 1'b1;
      mem_addr_o = if_addr_i;
    end else if (winner == OWN_DATA) begin
      mem_en_o    = 1'b1;
      mem_we_o    = d_we_i;
      mem_addr_o  = d_addr_i;
      mem_wdata_o = d_wdata_i;
      mem_be_o    = d_be_i;
    end
  end

  // Responses appear the cycle after the grant. Read data is passed
  // straight through from the RAM in that cycle and held afterwards.
  assign if_rvalid_o = (rsp_owner_q == OWN_FETCH);
  assign d_rvalid_o  = (rsp_owner_q == OWN_DATA);
  assign if_rdata_o  = if_rvalid_o ? mem_rdata_i : if_rdata_q;
  assign d_rdata_o   = (d_rvalid_o && !rsp_we_q) ? mem_rdata_i : d_rdata_q;
  assign conflict_cnt_o = cnt_q;

  // Compute next state: pointer and counter move only on contention,
  // the response owner follows the winner every cycle.
  always_comb begin
    last_winner_d = last_winner_q;
    if (contention) begin
      last_winner_d = winner;
    end
    rsp_owner_d = winner;
    rsp_we_d    = (winner == OWN_DATA) && d_we_i;
    if_rdata_d  = if_rdata_o;
    d_rdata_d   = d_rdata_o;
    cnt_d       = cnt_q;
    if (contention && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CNT_ONE;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_winner_q <= OWN_FETCH;
      rsp_owner_q   <= OWN_NONE;
      rsp_we_q      <= 1'b0;
      if_rdata_q    <= '0;
      d_rdata_q     <= '0;
      cnt_q         <= '0;
    end else begin
      last_winner_q <= last_winner_d;
      rsp_owner_q   <= rsp_owner_d;
      rsp_we_q      <= rsp_we_d;
      if_rdata_q    <= if_rdata_d;
      d_rdata_q     <= d_rdata_d;
      cnt_q         <= cnt_d;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed testbench for mem_port_arbiter. Each cycle the bench drives the
// requests, checks grants and RAM-side outputs, and pushes the expected
// response onto a scoreboard queue that the following cycle pops and checks.
module tb_mem_port_arbiter;

  localparam int AW = 10;
  localparam int DW = 32;
  localparam int BW = 4;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          if_req_i;
  logic [AW-1:0] if_addr_i;
  logic          if_gnt_o, if_rvalid_o;
  logic [DW-1:0] if_rdata_o;
  logic          d_req_i, d_we_i;
  logic [AW-1:0] d_addr_i;
  logic [DW-1:0] d_wdata_i;
  logic [BW-1:0] d_be_i;
  logic          d_gnt_o, d_rvalid_o;
  logic [DW-1:0] d_rdata_o;
  logic          mem_en_o, mem_we_o;
  logic [AW-1:0] mem_addr_o;
  logic [DW-1:0] mem_wdata_o;
  logic [BW-1:0] mem_be_o;
  logic [DW-1:0] mem_rdata_i;
  logic          stall_o;
  logic [CW-1:0] conflict_cnt_o;

  mem_port_arbiter #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TRANSFER_WIDTH(BW), .CNT_WIDTH(CW)
  ) dut (
    .clk(clk), .rst(rst),
    .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_gnt_o(if_gnt_o),
    .if_rvalid_o(if_rvalid_o), .if_rdata_o(if_rdata_o),
    .d_req_i(d_req_i), .d_we_i(d_we_i), .d_addr_i(d_addr_i),
    .d_wdata_i(d_wdata_i), .d_be_i(d_be_i), .d_gnt_o(d_gnt_o),
    .d_rvalid_o(d_rvalid_o), .d_rdata_o(d_rdata_o),
    .mem_en_o(mem_en_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_be_o(mem_be_o), .mem_rdata_i(mem_rdata_i),
    .stall_o(stall_o), .conflict_cnt_o(conflict_cnt_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic f;
    logic d;
    logic we;
  } rsp_t;

  rsp_t          sb_q[$];
  int            checks = 0;
  int            failures = 0;
  logic [DW-1:0] exp_if_rdata = '0;
  logic [DW-1:0] exp_d_rdata = '0;
  logic [CW-1:0] exp_cnt = '0;

  task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // One clock cycle: drive, check same-cycle outputs, check the response
  // owed from the previous cycle, push this cycle's expected response.
  task automatic cyc(input logic r, input logic iq, input logic [AW-1:0] ia,
                     input logic dq, input logic dwe, input logic [AW-1:0] da,
                     input logic [DW-1:0] wd, input logic [BW-1:0] be,
                     input logic eig, input logic edg, input logic [DW-1:0] rsp);
    rsp_t e;
    @(negedge clk);
    rst = r; if_req_i = iq; if_addr_i = ia;
    d_req_i = dq; d_we_i = dwe; d_addr_i = da; d_wdata_i = wd; d_be_i = be;
    mem_rdata_i = rsp;
    #1;
    chk("if_gnt", 32'(if_gnt_o), 32'(eig));
    chk("d_gnt", 32'(d_gnt_o), 32'(edg));
    chk("mem_en", 32'(mem_en_o), 32'(eig | edg));
    chk("mem_we", 32'(mem_we_o), 32'(edg & dwe));
    chk("mem_addr", 32'(mem_addr_o), eig ? 32'(ia) : (edg ? 32'(da) : 32'd0));
    chk("mem_wdata", mem_wdata_o, edg ? wd : 32'd0);
    chk("mem_be", 32'(mem_be_o), edg ? 32'(be) : 32'd0);
    chk("stall", 32'(stall_o), 32'(!r && ((iq && !eig) || (dq && !edg))));
    chk("conflict_cnt", 32'(conflict_cnt_o), 32'(exp_cnt));
    if (sb_q.size() == 0) begin
      checks++; failures++;
      $error("FAIL scoreboard observed=empty expected=entry");
    end else begin
      e = sb_q.pop_front();
      if (e.f) exp_if_rdata = rsp;
      if (e.d && !e.we) exp_d_rdata = rsp;
      chk("if_rvalid", 32'(if_rvalid_o), 32'(e.f));
      chk("d_rvalid", 32'(d_rvalid_o), 32'(e.d));
      chk("if_rdata", if_rdata_o, exp_if_rdata);
      chk("d_rdata", d_rdata_o, exp_d_rdata);
    end
    sb_q.push_back('{f: eig, d: edg, we: edg & dwe});
    if (r) begin
      exp_if_rdata = '0; exp_d_rdata = '0; exp_cnt = '0;
    end else if (iq && dq && exp_cnt != {CW{1'b1}}) begin
      exp_cnt = exp_cnt + 1'b1;
    end
    $display("cyc t=%0t rst=%0b req=%0b%0b gnt=%0b%0b rvalid=%0b%0b cnt=%0d",
             $time, r, iq, dq, if_gnt_o, d_gnt_o, if_rvalid_o, d_rvalid_o, conflict_cnt_o);
  endtask

  initial begin
    rst = 1'b1; if_req_i = 1'b1; if_addr_i = '0; d_req_i = 1'b1; d_we_i = 1'b0;
    d_addr_i = '0; d_wdata_i = '0; d_be_i = '0; mem_rdata_i = '0;
    @(posedge clk);
    sb_q.push_back('{f: 1'b0, d: 1'b0, we: 1'b0});

    // Reset with both requests high: no grants, no responses.
    cyc(1, 1, 10'h001, 1, 0, 10'h002, 32'h0, 4'h0, 0, 0, 32'h1111);
    cyc(1, 1, 10'h001, 1, 0, 10'h002, 32'h0, 4'h0, 0, 0, 32'h2222);
    cyc(0, 0, 10'h000, 0, 0, 10'h000, 32'h0, 4'h0, 0, 0, 32'h3333);

    // Sustained contention: DATA, FETCH, DATA, FETCH.
    cyc(0, 1, 10'h100, 1, 0, 10'h200, 32'h0, 4'h0, 0, 1, 32'h0);
    cyc(0, 1, 10'h100, 1, 0, 10'h201, 32'h0, 4'h0, 1, 0, 32'hA0000001);
    cyc(0, 1, 10'h101, 1, 0, 10'h201, 32'h0, 4'h0, 0, 1, 32'hA0000002);
    cyc(0, 1, 10'h101, 1, 0, 10'h202, 32'h0, 4'h0, 1, 0, 32'hA0000003);

    // Fetch only, then idle cycles to observe the held read data.
    cyc(0, 1, 10'h004, 0, 0, 10'h000, 32'h0, 4'h0, 1, 0, 32'hA0000004);
    cyc(0, 0, 10'h000, 0, 0, 10'h000, 32'h0, 4'h0, 0, 0, 32'h00500093);
    cyc(0, 0, 10'h000, 0, 0, 10'h000, 32'h0, 4'h0, 0, 0, 32'hFFFFFFFF);

    // Data read, then a data write whose response must not touch d_rdata.
    cyc(0, 0, 10'h000, 1, 0, 10'h020, 32'h0, 4'h0, 0, 1, 32'h0);
    cyc(0, 0, 10'h000, 1, 1, 10'h010, 32'hDEADBEEF, 4'b0011, 0, 1, 32'h12345678);
    cyc(0, 0, 10'h000, 0, 0, 10'h000, 32'h0, 4'h0, 0, 0, 32'hAAAA5555);

    // Uncontended data grant keeps the pointer at FETCH: contention grants DATA.
    cyc(0, 0, 10'h000, 1, 0, 10'h030, 32'h0, 4'h0, 0, 1, 32'h0);
    cyc(0, 1, 10'h040, 1, 0, 10'h031, 32'h0, 4'h0, 0, 1, 32'hB0000001);

    // Twenty contention cycles saturate the 4-bit counter at 15.
    for (int i = 0; i < 20; i++) begin
      cyc(0, 1, 10'h050, 1, 0, 10'h060, 32'h0, 4'h0,
          (i % 2) == 0, (i % 2) == 1, 32'hC0000000 + 32'(i));
    end
    cyc(0, 0, 10'h000, 0, 0, 10'h000, 32'h0, 4'h0, 0, 0, 32'hC0000099);
    cyc(0, 0, 10'h000, 0, 0, 10'h000, 32'h0, 4'h0, 0, 0, 32'h0);

    // Reset right after a fetch grant: response still arrives, then all clears.
    cyc(0, 1, 10'h070, 0, 0, 10'h000, 32'h0, 4'h0, 1, 0, 32'h0);
    cyc(1, 1, 10'h071, 1, 0, 10'h072, 32'h0, 4'h0, 0, 0, 32'hD0000001);
    cyc(0, 0, 10'h000, 0, 0, 10'h000, 32'h0, 4'h0, 0, 0, 32'hD0000002);
    cyc(0, 1, 10'h080, 1, 0, 10'h090, 32'h0, 4'h0, 0, 1, 32'h0);
    cyc(0, 0, 10'h000, 0, 0, 10'h000, 32'h0, 4'h0, 0, 0, 32'hD0000003);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
